green_feature_extractor: RTL and testbench
==========================================

Name: green_feature_extractor

Overview:
- Streaming front end of the rock-paper-scissors classifier.
- Accepts a raster pixel stream from the camera/image loader and thresholds each pixel against the green window into a 1-bit mask.
- Accumulates the total and left-region green counts, finds the leftmost green column, then reads back that column's mask bits as a vertical strip.
- Presents {sum, sum_left, leftmost, strip} to the downstream classifier through a valid/ready handshake.

Parameters:
- LENGTH, 32: image rows.
- WIDTH, 32: image columns.
- LEFT, 16: columns 0..LEFT-1 count toward sum_left.
- LOWER_GREEN_ONE, 0: channel 0 inclusive lower bound.
- UPPER_GREEN_ONE, 100: channel 0 inclusive upper bound.
- LOWER_GREEN_TWO, 100: channel 1 inclusive lower bound.
- UPPER_GREEN_TWO, 255: channel 1 inclusive upper bound.
- LOWER_GREEN_THREE, 0: channel 2 inclusive lower bound.
- UPPER_GREEN_THREE, 100: channel 2 inclusive upper bound.
- STRIP_OFFSET, 8: column offset added to leftmost. Used only under RPS_STRIP_OFFSET_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- init_in  in  1  start pulse; begins frame capture when IDLE.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  block accepts pixel.
- pix_data  in  24  [7:0]=ch0, [15:8]=ch1, [23:16]=ch2.
- busy  out  1  high in any state except IDLE.
- feat_valid  out  1  feature bundle valid.
- feat_ready  in  1  consumer accepts bundle.
- sum  out  32  green pixel count.
- sum_left  out  32  green count in columns < LEFT.
- leftmost  out  32  leftmost green column index.
- has_hand  out  1  at least one green pixel in frame.
- strip  out  LENGTH  mask bits of the selected column; bit r = row r.

Behaviour:
- Reset (rst_n low, async): state IDLE; pix_ready=0, feat_valid=0, busy=0, sum=0, sum_left=0, leftmost=0, has_hand=0, strip=0; row/col counters 0. Mask RAM contents are don't-care.
- FSM states: IDLE, CAPTURE, STRIP, DONE.
- IDLE: init_in=1 -> CAPTURE. On the same edge, clear sum, sum_left, leftmost, has_hand, strip and counters; set leftmost register to WIDTH (sentinel).
- CAPTURE: pix_ready=1. A pixel transfers when pix_valid&&pix_ready. Pixels arrive row-major: row 0 cols 0..WIDTH-1, then row 1, and so on.
  - mask = all three channels inside their inclusive [LOWER,UPPER] window.
  - Write mask to RAM[row][col].
  - sum += mask; sum_left += mask when col < LEFT.
  - If mask && col < leftmost, leftmost <= col.
  - Column wraps at WIDTH-1 with row increment.
  - After the transfer at row LENGTH-1, col WIDTH-1 -> STRIP.
  - pix_valid low stalls without side effects.
- STRIP:
  - pix_ready=0.
  - If the sentinel is still WIDTH, has_hand<=0, leftmost<=0, strip stays 0.
  - Otherwise has_hand<=1 and the block reads RAM rows 0..LENGTH-1 of column sel = leftmost, one row per cycle, registered read, filling strip[r].
  - STRIP lasts exactly LENGTH+1 cycles regardless of has_hand, then -> DONE.
- DONE: feat_valid=1. All outputs held stable until feat_valid&&feat_ready, then -> IDLE with feat_valid=0 on that edge.
- Latency: feat_valid rises exactly LENGTH+2 clocks after the edge that accepts the final pixel.
- init_in is ignored outside IDLE.
- Reset asserted mid-frame aborts immediately. The next frame requires a fresh init_in.
- Counters are 32-bit and never saturate: max count is LENGTH*WIDTH.

Optional Feature:
- Macro RPS_STRIP_OFFSET_EN.
- Defined: strip column sel = min(leftmost+STRIP_OFFSET, WIDTH-1). The leftmost output still reports the true leftmost column.
- Undefined: sel = leftmost, and STRIP_OFFSET is unused.

Test Plan:
Benches use LENGTH=4, WIDTH=4, LEFT=2. Green pixel G = ch0=50, ch1=200, ch2=50. Black pixel B = all zeros.
1. All-B frame -> sum=0, sum_left=0, has_hand=0, leftmost=0, strip=4'b0000; feat_valid exactly 6 clocks after the last pixel edge.
2. G at (0,3), (2,1), (3,1); rest B -> sum=3, sum_left=2, leftmost=1, has_hand=1, strip=4'b1100.
3. Case 2 with pix_valid dropped for 3 cycles after every pixel and feat_ready held low 5 cycles -> identical results; outputs stable while stalled; no pixel lost or duplicated.
4. Boundary thresholds: pixel ch0=100, ch1=100, ch2=0 -> counted. ch0=101 -> not counted. All-G frame -> sum=16, sum_left=8, leftmost=0, strip=4'b1111.
5. rst_n pulsed low after 7 pixels, then full case-2 frame after init_in -> case-2 results. init_in pulsed during CAPTURE -> no effect.
6. RPS_STRIP_OFFSET_EN, STRIP_OFFSET=2, G at (1,1), (2,3), (0,3) -> leftmost=1, sel=3, strip=4'b0101. G only at (3,3) -> sel clamps to 3, strip=4'b1000.

Source files
------------

// File: rtl/green_feature_extractor_if.sv
// rtl/green_feature_extractor_if.sv - pixel stream and feature bundle interface
//
// Purpose: groups the pixel input handshake and the feature output handshake.
// Ports (signals):
//   pix_valid/pix_ready/pix_data  pixel stream into the extractor
//   feat_valid/feat_ready         feature bundle handshake out of the extractor
//   sum/sum_left/leftmost/has_hand/strip  feature bundle payload
// Modports: master = pixel source / feature consumer, slave = extractor.
interface green_feature_extractor_if #(
    parameter int LENGTH = 32
) ();
    logic              pix_valid;
    logic              pix_ready;
    logic [23:0]       pix_data;
    logic              feat_valid;
    logic              feat_ready;
    logic [31:0]       sum;
    logic [31:0]       sum_left;
    logic [31:0]       leftmost;
    logic              has_hand;
    logic [LENGTH-1:0] strip;

    modport master (
        output pix_valid, pix_data, feat_ready,
        input  pix_ready, feat_valid, sum, sum_left, leftmost, has_hand, strip
    );

    modport slave (
        input  pix_valid, pix_data, feat_ready,
        output pix_ready, feat_valid, sum, sum_left, leftmost, has_hand, strip
    );
endinterface

// File: rtl/green_feature_extractor.sv
// rtl/green_feature_extractor.sv - green mask front end of the rps classifier
//
// Purpose: thresholds a raster pixel stream into a green mask, counts green
// pixels (total and left region), finds the leftmost green column and reads
// that column back from the mask RAM as a vertical strip.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   init_in  start pulse, honoured only in IDLE
//   busy     high whenever not IDLE
//   bus      green_feature_extractor_if.slave (pixel stream in, features out)
// Optional feature: define RPS_STRIP_OFFSET_EN to read the strip from column
// min(leftmost+STRIP_OFFSET, WIDTH-1) instead of the leftmost column.
module green_feature_extractor #(
    parameter int LENGTH            = 32,
    parameter int WIDTH             = 32,
    parameter int LEFT              = 16,
    parameter int LOWER_GREEN_ONE   = 0,
    parameter int UPPER_GREEN_ONE   = 100,
    parameter int LOWER_GREEN_TWO   = 100,
    parameter int UPPER_GREEN_TWO   = 255,
    parameter int LOWER_GREEN_THREE = 0,
    parameter int UPPER_GREEN_THREE = 100,
    parameter int STRIP_OFFSET      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_in,
    output logic                     busy,
    green_feature_extractor_if.slave bus
);
    localparam int RW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_STRIP,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [RW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [31:0]       r_sum;
    logic [31:0]       r_sum_left;
    logic [31:0]       r_leftmost;
    logic              r_has_hand;
    logic [LENGTH-1:0] r_strip;
    logic              r_feat_valid;
    logic [31:0]       r_strip_cnt;
    logic              r_rd_bit;
    logic              r_rd_vld;
    logic [RW-1:0]     r_rd_row;

    // Mask RAM, one word per row; contents need no reset.
    logic [WIDTH-1:0]  r_mask_ram [LENGTH];

    logic              w_xfer;
    logic              w_mask;
    logic              w_last_pix;
    logic              w_strip_end;
    logic [31:0]       w_sel_full;
    logic [CW-1:0]     w_sel;

    always_comb begin
        w_mask = (int'(bus.pix_data[7:0])   >= LOWER_GREEN_ONE)   &&
                 (int'(bus.pix_data[7:0])   <= UPPER_GREEN_ONE)   &&
                 (int'(bus.pix_data[15:8])  >= LOWER_GREEN_TWO)   &&
                 (int'(bus.pix_data[15:8])  <= UPPER_GREEN_TWO)   &&
                 (int'(bus.pix_data[23:16]) >= LOWER_GREEN_THREE) &&
                 (int'(bus.pix_data[23:16]) <= UPPER_GREEN_THREE);
    end

    assign w_xfer      = bus.pix_valid && (r_state == S_CAPTURE);
    assign w_last_pix  = (r_row == RW'(LENGTH - 1)) && (r_col == CW'(WIDTH - 1));
    assign w_strip_end = (r_strip_cnt == 32'(LENGTH));

`ifdef RPS_STRIP_OFFSET_EN
    // Read further right into the hand, clamped to the last column.
    assign w_sel_full = ((r_leftmost + 32'(STRIP_OFFSET)) > 32'(WIDTH - 1)) ?
                        32'(WIDTH - 1) : (r_leftmost + 32'(STRIP_OFFSET));
`else
    assign w_sel_full = r_leftmost;
`endif
    // When no hand was seen the sentinel may truncate to any column; the strip
    // write is gated by has_hand so the value read then does not matter.
    assign w_sel = w_sel_full[CW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        busy          = (r_state != S_IDLE);
        bus.pix_ready = (r_state == S_CAPTURE);
        case (r_state)
            S_IDLE:    if (init_in) w_next = S_CAPTURE;
            S_CAPTURE: if (w_xfer && w_last_pix) w_next = S_STRIP;
            S_STRIP:   if (w_strip_end) w_next = S_DONE;
            S_DONE:    if (r_feat_valid && bus.feat_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mask_ram[r_row][r_col] <= w_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row        <= '0;
            r_col        <= '0;
            r_sum        <= '0;
            r_sum_left   <= '0;
            r_leftmost   <= '0;
            r_has_hand   <= 1'b0;
            r_strip      <= '0;
            r_feat_valid <= 1'b0;
            r_strip_cnt  <= '0;
            r_rd_bit     <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_rd_row     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rd_vld     <= 1'b0;
                    r_feat_valid <= 1'b0;
                    if (init_in) begin
                        r_row       <= '0;
                        r_col       <= '0;
                        r_sum       <= '0;
                        r_sum_left  <= '0;
                        r_leftmost  <= 32'(WIDTH);
                        r_has_hand  <= 1'b0;
                        r_strip     <= '0;
                        r_strip_cnt <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_strip_cnt <= '0;
                    if (w_xfer) begin
                        r_sum <= r_sum + 32'(w_mask);
                        if (32'(r_col) < 32'(LEFT)) begin
                            r_sum_left <= r_sum_left + 32'(w_mask);
                        end
                        if (w_mask && (32'(r_col) < r_leftmost)) begin
                            r_leftmost <= 32'(r_col);
                        end
                        if (r_col == CW'(WIDTH - 1)) begin
                            r_col <= '0;
                            r_row <= w_last_pix ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_STRIP: begin
                    r_strip_cnt <= r_strip_cnt + 32'd1;
                    // Sentinel still at WIDTH means no green pixel this frame.
                    if (r_strip_cnt == 32'd0) begin
                        if (r_leftmost == 32'(WIDTH)) begin
                            r_has_hand <= 1'b0;
                            r_leftmost <= '0;
                        end else begin
                            r_has_hand <= 1'b1;
                        end
                    end
                    // Registered read: row issued in cycle c lands in strip in c+1.
                    if (r_strip_cnt < 32'(LENGTH)) begin
                        r_rd_bit <= r_mask_ram[r_strip_cnt[RW-1:0]][w_sel];
                        r_rd_row <= r_strip_cnt[RW-1:0];
                        r_rd_vld <= 1'b1;
                    end else begin
                        r_rd_vld <= 1'b0;
                    end
                    if (r_rd_vld && r_has_hand) begin
                        r_strip[r_rd_row] <= r_rd_bit;
                    end
                end
                S_DONE: begin
                    r_rd_vld     <= 1'b0;
                    r_feat_valid <= !(r_feat_valid && bus.feat_ready);
                end
                default: begin
                    r_rd_vld     <= 1'b0;
                    r_feat_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.feat_valid = r_feat_valid;
    assign bus.sum        = r_sum;
    assign bus.sum_left   = r_sum_left;
    assign bus.leftmost   = r_leftmost;
    assign bus.has_hand   = r_has_hand;
    assign bus.strip      = r_strip;
endmodule

// File: tb/tb_green_feature_extractor.sv
// tb/tb_green_feature_extractor.sv - directed table-driven bench for green_feature_extractor
module tb_green_feature_extractor;
    localparam int L = 4;
    localparam int W = 4;
`ifdef RPS_STRIP_OFFSET_EN
    localparam bit OFF_EN = 1'b1;
`else
    localparam bit OFF_EN = 1'b0;
`endif
    localparam logic [23:0] G = {8'd50, 8'd200, 8'd50};
    localparam logic [23:0] B = 24'h000000;

    logic clk = 1'b0;
    logic rst_n;
    logic init_in;
    logic busy;

    green_feature_extractor_if #(.LENGTH(L)) bus ();

    green_feature_extractor #(
        .LENGTH(L), .WIDTH(W), .LEFT(2), .STRIP_OFFSET(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .init_in(init_in),
        .busy   (busy),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] gmap;
        int          alt_idx;
        logic [23:0] alt_pix;
        int          gap;
        int          hold;
        logic [31:0] e_sum;
        logic [31:0] e_left;
        logic [31:0] e_lm;
        logic        e_hh;
        logic [3:0]  e_strip_nom;
        logic [3:0]  e_strip_off;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v, input bit inj_init);
        logic [23:0] pix;
        logic [3:0]  e_strip;
        int          lat;
        e_strip = OFF_EN ? v.e_strip_off : v.e_strip_nom;
        init_in = 1'b1;
        tick();
        init_in = 1'b0;
        chk({v.name, " start busy/ready"}, {62'd0, busy, bus.pix_ready}, 64'd3);
        for (int i = 0; i < L * W; i++) begin
            pix = v.gmap[i] ? G : B;
            if (i == v.alt_idx) pix = v.alt_pix;
            bus.pix_valid = 1'b1;
            bus.pix_data  = pix;
            if (inj_init && i == 5) init_in = 1'b1;
            tick();
            init_in = 1'b0;
            if (i != L * W - 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    bus.pix_valid = 1'b0;
                    bus.pix_data  = G;
                    tick();
                end
            end
        end
        bus.pix_valid = 1'b0;
        bus.pix_data  = B;
        lat = 0;
        while (!bus.feat_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk({v.name, " latency"}, 64'(lat), 64'd6);
        chk({v.name, " sum"}, 64'(bus.sum), 64'(v.e_sum));
        chk({v.name, " sum_left"}, 64'(bus.sum_left), 64'(v.e_left));
        chk({v.name, " leftmost"}, 64'(bus.leftmost), 64'(v.e_lm));
        chk({v.name, " has_hand"}, 64'(bus.has_hand), 64'(v.e_hh));
        chk({v.name, " strip"}, 64'(bus.strip), 64'(e_strip));
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk({v.name, " hold stable"},
                {bus.feat_valid, bus.has_hand, bus.strip, bus.sum[7:0], bus.sum_left[7:0], bus.leftmost[7:0]},
                {1'b1, v.e_hh, e_strip, v.e_sum[7:0], v.e_left[7:0], v.e_lm[7:0]});
        end
        bus.feat_ready = 1'b1;
        tick();
        bus.feat_ready = 1'b0;
        chk({v.name, " back to idle"}, {62'd0, busy, bus.feat_valid}, 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //         name            gmap      alt  alt_pix     gap hold sum left lm hh nom      off
        vecs[0] = '{"all_black",    16'h0000, -1, B,           0, 0,   0,  0,  0, 0, 4'b0000, 4'b0000};
        vecs[1] = '{"case2",        16'h2208, -1, B,           0, 0,   3,  2,  1, 1, 4'b1100, 4'b0001};
        vecs[2] = '{"case2_stall",  16'h2208, -1, B,           3, 5,   3,  2,  1, 1, 4'b1100, 4'b0001};
        vecs[3] = '{"all_green",    16'hFFFF, -1, B,           0, 0,  16,  8,  0, 1, 4'b1111, 4'b1111};
        vecs[4] = '{"lower_edge",   16'h0000,  6, 24'h006464,  0, 0,   1,  0,  2, 1, 4'b0010, 4'b0000};
        vecs[5] = '{"ch0_101",      16'h0000,  0, 24'h006465,  0, 0,   0,  0,  0, 0, 4'b0000, 4'b0000};
        vecs[6] = '{"upper_edge",   16'h0000,  5, 24'h64FF00,  0, 0,   1,  1,  1, 1, 4'b0010, 4'b0000};
        vecs[7] = '{"offset_a",     16'h0828, -1, B,           0, 0,   3,  1,  1, 1, 4'b0010, 4'b0101};
        vecs[8] = '{"offset_clamp", 16'h8000, -1, B,           0, 0,   1,  0,  3, 1, 4'b1000, 4'b1000};
        vecs[9] = '{"col0_mix",     16'h1004, -1, B,           0, 0,   2,  1,  0, 1, 4'b1000, 4'b0001};

        rst_n          = 1'b0;
        init_in        = 1'b0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = B;
        bus.feat_ready = 1'b0;
        tick();
        tick();
        chk("reset ctrl", {61'd0, busy, bus.pix_ready, bus.feat_valid}, 64'd0);
        chk("reset sums", {bus.sum, bus.sum_left}, 64'd0);
        chk("reset lm/hh/strip", {27'd0, bus.leftmost, bus.has_hand, bus.strip}, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i], 1'b0);
            tick();
        end

        // Reset mid-frame, then a fresh frame with a stray init during capture.
        init_in = 1'b1;
        tick();
        init_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = G;
            tick();
        end
        bus.pix_valid = 1'b0;
        chk("pre-abort sum", 64'(bus.sum), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("async abort ctrl", {62'd0, busy, bus.pix_ready}, 64'd0);
        chk("async abort sum", 64'(bus.sum), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("no restart without init", {62'd0, busy, bus.pix_ready}, 64'd0);
        run_frame(vecs[1], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
